// File: rtl/tt_sweep_gen_pkg.sv
// Shared definitions for the truth-table sweep generator:
// FSM state encodings and the default per-vector hold length.
package tt_sweep_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int HOLD_CYCLES_DEFAULT = 100;

endpackage

// File: rtl/tt_sweep_gen_hold_timer.sv
// Per-vector hold counter. Produces a one-cycle expire pulse on the last
// hold cycle, which is the clock at which the response is sampled.
module hold_timer
   import tt_sweep_gen_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expire
);

   localparam int CNT_W = $clog2(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   assign w_at_last = (r_cnt == CNT_LAST);
   assign expire    = w_at_last && !clear;

   // Wrapping on the terminal compare keeps the counter from ever overflowing.
   always_ff @(posedge clk) begin
      if (rst || clear || w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tt_sweep_gen.sv
// Self-timed exhaustive sweep of a small combinational block: drives every
// input vector in ascending order and captures the response into a truth table.
module tt_sweep_gen
   import tt_sweep_gen_pkg::*;
#(
   parameter int N_IN        = 3,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   e_in,
   output logic [N_IN-1:0]        vec_out,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   tt_out
);

   localparam int N_VEC = 1 << N_IN;
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;
   logic              w_clear;
   logic              w_expire;
   logic              w_step;
   logic [N_IN-1:0]   r_vec;
   logic [N_VEC-1:0]  r_tt;
   logic [N_VEC-1:0]  w_tt_next;

   assign w_accept = start && (r_state != DRIVE);
   assign w_clear  = (r_state != DRIVE);
   assign w_step   = (r_state == DRIVE) && w_expire;

   hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_clear),
      .expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start) w_state_next = DRIVE;
         end
         DRIVE: begin
            if (w_step && (r_vec == VEC_LAST)) w_state_next = DONE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Each table bit only loads when the sweep samples its own vector.
   for (genvar gi = 0; gi < N_VEC; gi++) begin : g_tt_bit
      assign w_tt_next[gi] = w_accept ? 1'b0 :
                             ((w_step && (r_vec == N_IN'(gi))) ? e_in : r_tt[gi]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec <= '0;
         r_tt  <= '0;
      end else begin
         r_tt <= w_tt_next;
         if (w_accept) begin
            r_vec <= '0;
         end else if (w_step && (r_vec != VEC_LAST)) begin
            r_vec <= r_vec + N_IN'(1);
         end
      end
   end

   assign vec_out = r_vec;
   assign tt_out  = r_tt;
   assign busy    = (r_state == DRIVE);
   assign done    = (r_state == DONE);

endmodule
